button_event_servicer: RTL and testbench
========================================

// Module: button_event_servicer
// PURPOSE
//  Avalon-MM host for the 4-bit button edge-capture PIO slave (regs: 0=data, 2=irq_mask, 3=edge_capture).
//  Programs irq_mask after reset. On irq, or on a poll tick, it reads edge_capture, clears it, reads levels,
//  then presents one {edges, levels} event on a valid/ready stream to the audio-player control logic.
// PARAMETERS
//  WIDTH        4     button count; bits [WIDTH-1:0] of readdata are used, upper bits ignored
//  IRQ_MASK     4'hF  value written to reg 2 during init; upper writedata bits are 0
//  POLL_PERIOD  0     clocks between polls in IDLE; 0 = irq-driven only
// PORTS
//  clk            in   1      system clock
//  reset          in   1      synchronous, active-high
//  avm_address    out  2      slave register address
//  avm_chipselect out  1      one-cycle transfer strobe
//  avm_write_n    out  1      0 = write; low only while avm_chipselect=1
//  avm_writedata  out  32     write data
//  avm_readdata   in   32     slave readdata; registered, valid the cycle after the read address
//  irq            in   1      slave irq (edge_capture & irq_mask, level)
//  evt_valid      out  1      event available
//  evt_ready      in   1      consumer accepts when evt_valid & evt_ready
//  evt_edges      out  WIDTH  captured edge bits, always nonzero when valid
//  evt_levels     out  WIDTH  button levels sampled after the clear
//  init_done      out  1      1 once irq_mask has been written
// BEHAVIOUR
//  Reset (sync, clk edge): state=INIT; chipselect=0, write_n=1, address=0, writedata=0, evt_valid=0,
//   evt_edges=0, evt_levels=0, init_done=0, poll counter=0. Reset mid-transfer abandons the transfer;
//   held event dropped. No waitrequest exists: every transfer is exactly one cycle with chipselect=1.
//  FSM (one state per cycle unless noted):
//   INIT     : cs=1, write_n=0, addr=2, wdata=IRQ_MASK -> IDLE; init_done=1 from next cycle on.
//   IDLE     : cs=0. If irq=1, or poll counter hits POLL_PERIOD-1 (POLL_PERIOD>0) -> RD_CAP; counter
//              clears on entry to RD_CAP. Counter only advances in IDLE. irq and poll tick together = one read.
//   RD_CAP   : cs=1, write_n=1, addr=3 -> WAIT_CAP.
//   WAIT_CAP : cs=0; latch readdata[WIDTH-1:0] into edges. If zero (spurious/poll-empty) -> IDLE, else -> CLR.
//   CLR      : cs=1, write_n=0, addr=3, wdata=0 (slave clears all bits on any write) -> RD_LVL.
//   RD_LVL   : cs=1, write_n=1, addr=0 -> WAIT_LVL.
//   WAIT_LVL : cs=0; latch readdata[WIDTH-1:0] into levels -> EMIT.
//   EMIT     : evt_valid=1, evt_edges/evt_levels stable; stays until evt_ready=1, then -> IDLE
//              (evt_valid=0 from next cycle). evt_ready ignored in all other states.
//  Latency: irq high at cycle 0 -> RD_CAP cycle 1, CLR cycle 3, evt_valid first high cycle 6.
//  Stale irq: irq still high in the IDLE cycle right after EMIT (slave drops it 1 cycle after clear,
//   long before) cannot occur; irq high then denotes new edges and starts a new service.
//  Known race, accepted: an edge that the slave detects between the RD_CAP sample and the CLR write
//   is lost (slave gives clear priority). Its level still shows in evt_levels.
//  Backpressure: no new capture while EMIT is held; edges accumulate in the slave, nothing overflows.
//  Width: readdata bits above WIDTH-1 are ignored; writedata bits above WIDTH-1 are always 0.
// STRUCTURE
//  Shared header pio_defs.vh: PIO_REG_DATA=2'd0, PIO_REG_MASK=2'd2, PIO_REG_EDGE=2'd3, and state codes.
//  One sub-module: pio_poll_timer (POLL_PERIOD counter, enable=IDLE, clear, tick). Not instantiated
//   when POLL_PERIOD=0. FSM and datapath stay in this file.
// TESTING (bench instantiates the real PIO slave, clk shared; slave reset_n = ~reset)
//  1 Reset release -> one write to addr 2 with wdata=32'hF in the first cycle; init_done=1 next cycle.
//  2 Toggle in_port bit1 0->1, evt_ready=1 -> transfer sequence rd3, wr3, rd0; evt_edges=4'b0010,
//    evt_levels=4'b0010; irq low after CLR; evt_valid high exactly 1 cycle.
//  3 evt_ready=0 for 20 cycles, then toggle bit0 during the hold -> first event held stable; after
//    ready, second event evt_edges=4'b0001; no transfers on the bus during the hold.
//  4 IRQ_MASK=4'h0, POLL_PERIOD=8, toggle bit3 -> rd3 issued every 10 cycles (8 in IDLE + RD_CAP,
//    WAIT_CAP) while empty; event evt_edges=4'b1000.
//  5 Assert reset in RD_LVL with an event pending -> next cycle all outputs at reset values; INIT repeats.
//  6 Toggle bit2 on the cycle the slave samples the CLR write -> edge lost, evt_edges excludes bit2,
//    evt_levels bit2 shows the new level; no hang, FSM returns to IDLE.

Source files
------------

// File: rtl/button_event_servicer_pkg.sv
// Shared register map, FSM state codes and bus-command decode for the
// button edge-capture PIO servicer.
package button_event_servicer_pkg;

  // PIO slave register addresses
  localparam logic [1:0] PIO_REG_DATA = 2'd0;
  localparam logic [1:0] PIO_REG_MASK = 2'd2;
  localparam logic [1:0] PIO_REG_EDGE = 2'd3;

  // FSM state codes
  localparam logic [2:0] ST_INIT     = 3'd0;
  localparam logic [2:0] ST_IDLE     = 3'd1;
  localparam logic [2:0] ST_RD_CAP   = 3'd2;
  localparam logic [2:0] ST_WAIT_CAP = 3'd3;
  localparam logic [2:0] ST_CLR      = 3'd4;
  localparam logic [2:0] ST_RD_LVL   = 3'd5;
  localparam logic [2:0] ST_WAIT_LVL = 3'd6;
  localparam logic [2:0] ST_EMIT     = 3'd7;

  typedef struct packed {
    logic       cs;
    logic       write_n;
    logic [1:0] addr;
  } bus_cmd_t;

  // Avalon command driven in each state; idle bus is cs=0, write_n=1, addr=0
  function automatic bus_cmd_t bus_cmd(input logic [2:0] st);
    bus_cmd_t c;
    c = '{cs: 1'b0, write_n: 1'b1, addr: PIO_REG_DATA};
    case (st)
      ST_INIT:   c = '{cs: 1'b1, write_n: 1'b0, addr: PIO_REG_MASK};
      ST_RD_CAP: c = '{cs: 1'b1, write_n: 1'b1, addr: PIO_REG_EDGE};
      ST_CLR:    c = '{cs: 1'b1, write_n: 1'b0, addr: PIO_REG_EDGE};
      ST_RD_LVL: c = '{cs: 1'b1, write_n: 1'b1, addr: PIO_REG_DATA};
      default:   ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/button_event_servicer_pio_poll_timer.sv
// Poll interval counter: counts clocks while enabled and flags the last
// count of each period. Clear has priority over counting.
module pio_poll_timer #(
  parameter int unsigned PERIOD = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned   CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  // Next count: clear, advance while enabled, otherwise hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/button_event_servicer.sv
// Avalon-MM host for the button edge-capture PIO. Programs irq_mask after
// reset, then on irq or poll tick reads edge_capture, clears it, reads the
// levels and offers one {edges, levels} event on a valid/ready stream.
module button_event_servicer
  import button_event_servicer_pkg::*;
#(
  parameter int unsigned      WIDTH       = 4,
  parameter logic [WIDTH-1:0] IRQ_MASK    = '1,
  parameter int unsigned      POLL_PERIOD = 0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  input  logic             irq,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_edges,
  output logic [WIDTH-1:0] evt_levels,
  output logic             init_done
);

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] edges_q, edges_d;
  logic [WIDTH-1:0] levels_q, levels_d;
  logic             init_done_q;
  logic             in_idle;
  logic             poll_tick;
  logic             start_svc;
  bus_cmd_t         cmd;
  logic             rd_hi_unused;

  assign rd_hi_unused = ^avm_readdata[31:WIDTH];

  assign in_idle   = (state_q == ST_IDLE);
  assign start_svc = in_idle && (irq || poll_tick);

  if (POLL_PERIOD > 0) begin : g_poll
    pio_poll_timer #(
      .PERIOD (POLL_PERIOD)
    ) u_poll_timer (
      .clk_i   (clk),
      .reset_i (reset),
      .en_i    (in_idle),
      .clr_i   (start_svc),
      .tick_o  (poll_tick)
    );
  end else begin : g_no_poll
    assign poll_tick = 1'b0;
  end

  // Next state and capture of edge/level readdata in the wait states
  always_comb begin
    state_d  = state_q;
    edges_d  = edges_q;
    levels_d = levels_q;
    case (state_q)
      ST_INIT:     state_d = ST_IDLE;
      ST_IDLE:     if (start_svc) state_d = ST_RD_CAP;
      ST_RD_CAP:   state_d = ST_WAIT_CAP;
      ST_WAIT_CAP: begin
        edges_d = avm_readdata[WIDTH-1:0];
        state_d = (avm_readdata[WIDTH-1:0] == '0) ? ST_IDLE : ST_CLR;
      end
      ST_CLR:      state_d = ST_RD_LVL;
      ST_RD_LVL:   state_d = ST_WAIT_LVL;
      ST_WAIT_LVL: begin
        levels_d = avm_readdata[WIDTH-1:0];
        state_d  = ST_EMIT;
      end
      ST_EMIT:     if (evt_ready) state_d = ST_IDLE;
      default:     state_d = ST_INIT;
    endcase
  end

  // State, event payload and init flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      edges_q     <= '0;
      levels_q    <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      edges_q     <= edges_d;
      levels_q    <= levels_d;
      init_done_q <= init_done_q | (state_q == ST_INIT);
    end
  end

  // Bus is decoded from the state; the FSM sits in INIT for the whole of
  // reset, so the INIT write is masked until reset drops.
  assign cmd            = bus_cmd(state_q);
  assign avm_chipselect = cmd.cs & ~reset;
  assign avm_write_n    = cmd.write_n | reset;
  assign avm_address    = reset ? PIO_REG_DATA : cmd.addr;
  assign avm_writedata  = (state_q == ST_INIT && !reset) ?
                          {{(32-WIDTH){1'b0}}, IRQ_MASK} : '0;

  assign evt_valid  = (state_q == ST_EMIT);
  assign evt_edges  = edges_q;
  assign evt_levels = levels_q;
  assign init_done  = init_done_q;

endmodule

// File: tb/tb_button_event_servicer.sv
// Directed bench: two servicers (irq-driven and poll-only), each talking to
// a behavioural rising-edge-capture PIO slave on a shared clock.
module tb_button_event_servicer;

  localparam logic [3:0] B_IDLE   = 4'h4;  // {cs,write_n,addr} = 0,1,00
  localparam logic [3:0] B_MASKWR = 4'hA;  // 1,0,10
  localparam logic [3:0] B_RDCAP  = 4'hF;  // 1,1,11
  localparam logic [3:0] B_CLR    = 4'hB;  // 1,0,11
  localparam logic [3:0] B_RDLVL  = 4'hC;  // 1,1,00

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  addr_a, addr_b;
  logic        cs_a, cs_b, wn_a, wn_b;
  logic [31:0] wd_a, wd_b, rd_a, rd_b;
  logic        irq_a, irq_b, v_a, v_b, rdy_a, rdy_b, done_a, done_b;
  logic [3:0]  ed_a, ed_b, lv_a, lv_b;

  // slave model state, index 0 = DUT A, 1 = DUT B
  logic [1:0][3:0]  pin;
  logic [1:0][3:0]  ecap, mask, prev;
  logic [1:0][31:0] rdq;
  logic [1:0]       cs, wn;
  logic [1:0][1:0]  ad;
  logic [1:0][31:0] wd;

  assign cs = {cs_b, cs_a};
  assign wn = {wn_b, wn_a};
  assign ad = {addr_b, addr_a};
  assign wd = {wd_b, wd_a};
  assign rd_a  = rdq[0];
  assign rd_b  = rdq[1];
  assign irq_a = |(ecap[0] & mask[0]);
  assign irq_b = |(ecap[1] & mask[1]);

  button_event_servicer #(.WIDTH(4), .IRQ_MASK(4'hF), .POLL_PERIOD(0)) dut_a (
    .clk(clk), .reset(reset), .avm_address(addr_a), .avm_chipselect(cs_a),
    .avm_write_n(wn_a), .avm_writedata(wd_a), .avm_readdata(rd_a), .irq(irq_a),
    .evt_valid(v_a), .evt_ready(rdy_a), .evt_edges(ed_a), .evt_levels(lv_a),
    .init_done(done_a));

  button_event_servicer #(.WIDTH(4), .IRQ_MASK(4'h0), .POLL_PERIOD(8)) dut_b (
    .clk(clk), .reset(reset), .avm_address(addr_b), .avm_chipselect(cs_b),
    .avm_write_n(wn_b), .avm_writedata(wd_b), .avm_readdata(rd_b), .irq(irq_b),
    .evt_valid(v_b), .evt_ready(rdy_b), .evt_edges(ed_b), .evt_levels(lv_b),
    .init_done(done_b));

  // PIO slave: registered readdata, rising-edge capture, write to reg 3 clears
  // (clear wins over a same-cycle edge), reset_n = ~reset
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (reset) begin
        ecap[g] <= '0;
        mask[g] <= '0;
        prev[g] <= pin[g];
        rdq[g]  <= '0;
      end else begin
        prev[g] <= pin[g];
        rdq[g]  <= '0;
        if (cs[g] && wn[g]) begin
          case (ad[g])
            2'd0:    rdq[g] <= {28'd0, pin[g]};
            2'd2:    rdq[g] <= {28'd0, mask[g]};
            2'd3:    rdq[g] <= {28'd0, ecap[g]};
            default: rdq[g] <= '0;
          endcase
        end
        if (cs[g] && !wn[g] && ad[g] == 2'd2) mask[g] <= wd[g][3:0];
        if (cs[g] && !wn[g] && ad[g] == 2'd3) ecap[g] <= '0;
        else ecap[g] <= ecap[g] | (pin[g] & ~prev[g]);
      end
    end
  end

  int xa = 0;
  always @(posedge clk) if (cs_a) xa <= xa + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [3:0] busa();
    return {cs_a, wn_a, addr_a};
  endfunction

  function automatic logic [3:0] busb();
    return {cs_b, wn_b, addr_b};
  endfunction

  initial begin
    int n;
    int x0;
    logic ok;
    reset = 1'b1;
    pin   = '0;
    rdy_a = 1'b1;
    rdy_b = 1'b1;
    step(3);

    // reset state
    chk("rst_bus", busa(), B_IDLE);
    chk("rst_wdata", wd_a, 32'h0);
    chk("rst_valid", v_a, 1'b0);
    chk("rst_edges", ed_a, 4'h0);
    chk("rst_levels", lv_a, 4'h0);
    chk("rst_init_done", done_a, 1'b0);

    // 1: mask write in the first cycle after release
    reset = 1'b0;
    #1;
    chk("init_bus", busa(), B_MASKWR);
    chk("init_wdata", wd_a, 32'hF);
    chk("init_bus_b", busb(), B_MASKWR);
    chk("init_wdata_b", wd_b, 32'h0);
    step;
    chk("init_done", done_a, 1'b1);
    chk("init_idle", busa(), B_IDLE);
    chk("init_done_b", done_b, 1'b1);
    step(2);

    // 2: bit1 rising edge, consumer ready
    pin[0] = 4'b0010;
    step; chk("t2_irq", irq_a, 1'b1); chk("t2_idle", busa(), B_IDLE);
    step; chk("t2_rdcap", busa(), B_RDCAP);
    step; chk("t2_waitcap", busa(), B_IDLE);
    step; chk("t2_clr", busa(), B_CLR); chk("t2_clr_wdata", wd_a, 32'h0);
    step; chk("t2_rdlvl", busa(), B_RDLVL); chk("t2_irq_low", irq_a, 1'b0);
    step; chk("t2_waitlvl", busa(), B_IDLE); chk("t2_not_valid", v_a, 1'b0);
    step; chk("t2_valid", v_a, 1'b1); chk("t2_edges", ed_a, 4'b0010);
    chk("t2_levels", lv_a, 4'b0010);
    step; chk("t2_valid_once", v_a, 1'b0);
    step(2);

    // 3: backpressure, new edge accumulates in the slave during the hold
    rdy_a  = 1'b0;
    pin[0] = 4'b0110;
    step(7);
    chk("t3_valid", v_a, 1'b1);
    chk("t3_edges", ed_a, 4'b0100);
    chk("t3_levels", lv_a, 4'b0110);
    x0 = xa;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 4) pin[0] = 4'b0111;
      step;
      if (!v_a || ed_a != 4'b0100 || lv_a != 4'b0110) ok = 1'b0;
    end
    chk("t3_hold_stable", ok, 1'b1);
    chk("t3_hold_xfers", xa - x0, 0);
    chk("t3_irq_pending", irq_a, 1'b1);
    rdy_a = 1'b1;
    step;
    chk("t3_released", v_a, 1'b0);
    n = 0;
    while (!v_a && n < 20) begin
      step;
      n++;
    end
    chk("t3_ev2_latency", n, 6);
    chk("t3_ev2_edges", ed_a, 4'b0001);
    chk("t3_ev2_levels", lv_a, 4'b0111);
    step;
    chk("t3_ev2_done", v_a, 1'b0);

    // 4: poll-only instance, empty polls every 10 cycles
    n = 0;
    while (busb() != B_RDCAP && n < 20) begin
      step;
      n++;
    end
    chk("t4_first_poll_found", (n < 20), 1'b1);
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        step;
        n++;
      end while (busb() != B_RDCAP && n < 30);
      chk("t4_poll_period", n, 10);
    end
    pin[1] = 4'b1000;
    n = 0;
    while (!v_b && n < 40) begin
      step;
      n++;
    end
    chk("t4_evt_latency", n, 15);
    chk("t4_edges", ed_b, 4'b1000);
    chk("t4_levels", lv_b, 4'b1000);
    chk("t4_irq_masked", irq_b, 1'b0);

    // 5: reset while in RD_LVL with an event in flight
    step(2);
    pin[0] = 4'b1111;
    step; chk("t5_irq", irq_a, 1'b1);
    step(3); chk("t5_clr", busa(), B_CLR);
    step; chk("t5_rdlvl", busa(), B_RDLVL);
    reset = 1'b1;
    step;
    chk("t5_rst_bus", busa(), B_IDLE);
    chk("t5_rst_wdata", wd_a, 32'h0);
    chk("t5_rst_valid", v_a, 1'b0);
    chk("t5_rst_edges", ed_a, 4'h0);
    chk("t5_rst_levels", lv_a, 4'h0);
    chk("t5_rst_init_done", done_a, 1'b0);
    reset = 1'b0;
    #1;
    chk("t5_reinit_bus", busa(), B_MASKWR);
    chk("t5_reinit_wdata", wd_a, 32'hF);
    step;
    chk("t5_reinit_done", done_a, 1'b1);

    // 6: edge arriving in the CLR cycle is lost, its level is still seen
    pin[0] = 4'b0000;
    step(3);
    chk("t6_quiet_irq", irq_a, 1'b0);
    pin[0] = 4'b0010;
    step(3);
    step; chk("t6_clr", busa(), B_CLR);
    pin[0] = 4'b0110;
    step; chk("t6_irq_after_clr", irq_a, 1'b0);
    step(2);
    chk("t6_valid", v_a, 1'b1);
    chk("t6_edges", ed_a, 4'b0010);
    chk("t6_levels", lv_a, 4'b0110);
    x0 = xa;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step;
      if (v_a || busa() != B_IDLE) ok = 1'b0;
    end
    chk("t6_back_idle", ok, 1'b1);
    chk("t6_no_xfers", xa - x0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
